// File: rtl/chi_plane_worker.sv
// ---------------------------------------------------------------------------
// chi_plane_worker
//
// Worker instance of the revaluate (chi) stage. On a start request taken in
// IDLE it walks the 5x5 lane state held in an attached registered memory one
// plane (y) at a time: the five lanes of the plane are read into a row
// buffer, the chi nonlinearity
//     a'[x] = a[x] ^ (~a[x+1] & a[x+2])      (indices mod 5)
// is applied, and the five results are written back in place.
//
// Per plane: 5 READ + 1 LAST + 5 WRITE = 11 cycles; a job is 55 cycles.
//
// Ports
//   clk        : clock
//   rst        : asynchronous, active-high reset
//   start      : launch request, only looked at while IDLE
//   ready      : high while IDLE, low while a job is in flight
//   mem_addr   : lane address 5*y + x (0..24), 0 when no strobe is active
//   mem_rd     : read strobe (data returns on mem_rdata one cycle later)
//   mem_rdata  : read data from the registered state memory
//   mem_wr     : write strobe
//   mem_wdata  : write data, 0 when mem_wr is low
// ---------------------------------------------------------------------------
module chi_plane_worker #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         ready,
    output logic [4:0]   mem_addr,
    output logic         mem_rd,
    input  logic [W-1:0] mem_rdata,
    output logic         mem_wr,
    output logic [W-1:0] mem_wdata
);

    // State encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] LAST  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    localparam logic [2:0] LANE_MAX = 3'd4;

    logic [1:0]   ps_reg;
    logic [1:0]   ps_next;
    logic [2:0]   x_reg;
    logic [2:0]   x_next;
    logic [2:0]   y_reg;
    logic [2:0]   y_next;

    // Row buffer: the five lanes of the plane currently being processed.
    logic [W-1:0] r_reg  [5];
    logic [W-1:0] r_next [5];

    // Per-lane capture enables and per-lane chi results.
    logic [4:0]   cap_en;
    logic [W-1:0] chi_lane [5];

    logic [4:0]   lane_addr;

    // -----------------------------------------------------------------------
    // Sequencing
    // -----------------------------------------------------------------------
    always_comb begin
        ps_next = ps_reg;
        x_next  = x_reg;
        y_next  = y_reg;
        case (ps_reg)
            IDLE: begin
                if (start) begin
                    ps_next = READ;
                    x_next  = 3'd0;
                    y_next  = 3'd0;
                end
            end
            READ: begin
                if (x_reg == LANE_MAX) begin
                    ps_next = LAST;
                    x_next  = 3'd0;
                end else begin
                    x_next = x_reg + 3'd1;
                end
            end
            LAST: begin
                // The last lane's read data arrives here; the write phase
                // only starts once the whole row is buffered, which is what
                // makes the in-place update safe.
                ps_next = WRITE;
            end
            WRITE: begin
                if (x_reg == LANE_MAX) begin
                    x_next = 3'd0;
                    if (y_reg == LANE_MAX) begin
                        ps_next = IDLE;
                        y_next  = 3'd0;
                    end else begin
                        ps_next = READ;
                        y_next  = y_reg + 3'd1;
                    end
                end else begin
                    x_next = x_reg + 3'd1;
                end
            end
            default: begin
                ps_next = IDLE;
                x_next  = 3'd0;
                y_next  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_reg <= IDLE;
            x_reg  <= 3'd0;
            y_reg  <= 3'd0;
        end else begin
            ps_reg <= ps_next;
            x_reg  <= x_next;
            y_reg  <= y_next;
        end
    end

    // -----------------------------------------------------------------------
    // Row buffer capture
    //
    // The memory is registered, so the lane addressed at READ x arrives one
    // cycle later: lane x-1 is captured while READ is at x (x >= 1), and
    // lane 4 is captured in LAST.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_row
            if (gi < 4) begin : g_in_read
                assign cap_en[gi] = (ps_reg == READ) && (x_reg == 3'(gi + 1));
            end else begin : g_in_last
                assign cap_en[gi] = (ps_reg == LAST);
            end

            assign r_next[gi] = cap_en[gi] ? mem_rdata : r_reg[gi];

            // chi for lane gi; the mod-5 wrap is resolved at elaboration.
            assign chi_lane[gi] = r_reg[gi] ^ (~r_reg[(gi + 1) % 5] & r_reg[(gi + 2) % 5]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                r_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                r_reg[i] <= r_next[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (purely from state, counters and row buffer)
    // -----------------------------------------------------------------------
    // 5*y + x = 4*y + y + x, all within 5 bits (max 24).
    assign lane_addr = ({2'b00, y_reg} << 2) + {2'b00, y_reg} + {2'b00, x_reg};

    always_comb begin
        ready     = (ps_reg == IDLE);
        mem_rd    = (ps_reg == READ);
        mem_wr    = (ps_reg == WRITE);
        mem_addr  = 5'd0;
        mem_wdata = '0;
        if (mem_rd || mem_wr) begin
            mem_addr = lane_addr;
        end
        if (mem_wr) begin
            case (x_reg)
                3'd0:    mem_wdata = chi_lane[0];
                3'd1:    mem_wdata = chi_lane[1];
                3'd2:    mem_wdata = chi_lane[2];
                3'd3:    mem_wdata = chi_lane[3];
                3'd4:    mem_wdata = chi_lane[4];
                default: mem_wdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_chi_plane_worker.sv
// ---------------------------------------------------------------------------
// tb_chi_plane_worker
//
// Self-checking bench for chi_plane_worker. A registered 25-lane memory
// model is attached to the worker. Expected memory contents come from a
// plain chi formula applied to the memory image taken before each job.
// Directed table vectors, randomized images and hand-written sequences
// (back-to-back jobs, asynchronous reset mid-job) are exercised.
// ---------------------------------------------------------------------------
module tb_chi_plane_worker;

    localparam int W = 64;
    localparam logic [W-1:0] ONES = '1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         ready;
    logic [4:0]   mem_addr;
    logic         mem_rd;
    logic [W-1:0] mem_rdata;
    logic         mem_wr;
    logic [W-1:0] mem_wdata;

    always #5 clk = ~clk;

    chi_plane_worker #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ready     (ready),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata)
    );

    // ---------------- memory model (registered read) ----------------
    logic [W-1:0] mem      [25];
    logic [W-1:0] load_img [25];
    logic [W-1:0] exp_mem  [25];
    logic [W-1:0] init_img [25];
    logic         load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 25; i++) mem[i] <= load_img[i];
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int rd_q[$];
    int wr_q[$];
    int rd0_q[$];

    task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // chi applied to the current memory image, plane by plane.
    function automatic void build_expected();
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                exp_mem[5*y + x] = mem[5*y + x] ^
                                   (~mem[5*y + (x + 1) % 5] & mem[5*y + (x + 2) % 5]);
            end
        end
        for (int i = 0; i < 25; i++) init_img[i] = mem[i];
    endfunction

    // Per-cycle protocol monitor.
    always @(negedge clk) begin
        cyc_cnt++;
        if (!rst) begin
            check_int("rd_wr_exclusive", int'(mem_rd & mem_wr), 0);
            if (!mem_rd && !mem_wr) check_int("addr_zero_no_strobe", int'(mem_addr), 0);
            if (!mem_wr) check_vec("wdata_zero_no_write", mem_wdata, '0);
            if (mem_rd) begin
                rd_q.push_back(int'(mem_addr));
                if (mem_addr == 5'd0) rd0_q.push_back(cyc_cnt);
            end
            if (mem_wr) begin
                wr_q.push_back(int'(mem_addr));
                check_vec($sformatf("wdata_addr%0d", mem_addr), mem_wdata, exp_mem[mem_addr]);
            end
        end
    end

    task automatic load_image();
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
        @(negedge clk);
    endtask

    // One complete job, optionally pulsing start at busy cycles pa/pb.
    task automatic run_job(input string name, input int pa, input int pb);
        int busy;
        build_expected();
        rd_q.delete();
        wr_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy = 0;
        while (ready === 1'b0 && busy < 100) begin
            busy++;
            start = (busy == pa || busy == pb);
            @(negedge clk);
        end
        start = 1'b0;
        check_int({name, "_busy_cycles"}, busy, 55);
        check_int({name, "_reads"}, rd_q.size(), 25);
        check_int({name, "_writes"}, wr_q.size(), 25);
        for (int k = 0; k < 25; k++) begin
            if (k < rd_q.size()) check_int($sformatf("%s_rd_order%0d", name, k), rd_q[k], k);
            if (k < wr_q.size()) check_int($sformatf("%s_wr_order%0d", name, k), wr_q[k], k);
            check_vec($sformatf("%s_mem%0d", name, k), mem[k], exp_mem[k]);
        end
        repeat (3) @(negedge clk);
        check_int({name, "_ready_after"}, int'(ready), 1);
        check_int({name, "_no_extra_job"}, rd_q.size(), 25);
        $display("job %s: busy=%0d reads=%0d writes=%0d", name, busy, rd_q.size(), wr_q.size());
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic [2:0]            plane;
        logic                  all_planes;
        int                    pulse_a;
        int                    pulse_b;
        logic [4:0][W-1:0]     lanes_in;
        logic [4:0][W-1:0]     lanes_exp;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // all-zero state, with ignored start pulses at busy cycles 1 and 30
        tbl[0] = '0;
        tbl[0].all_planes = 1'b1;
        tbl[0].pulse_a = 1;
        tbl[0].pulse_b = 30;
        // single lane in plane 0
        tbl[1] = '0;
        tbl[1].plane = 3'd0;
        tbl[1].lanes_in[2]  = ONES;
        tbl[1].lanes_exp[0] = ONES;
        tbl[1].lanes_exp[2] = ONES;
        // wrap-around in plane 3: lane0 set -> lanes 0 and 3 set
        tbl[2] = '0;
        tbl[2].plane = 3'd3;
        tbl[2].lanes_in[0]  = ONES;
        tbl[2].lanes_exp[0] = ONES;
        tbl[2].lanes_exp[3] = ONES;
        // all-ones everywhere is a fixed point
        tbl[3] = '0;
        tbl[3].all_planes = 1'b1;
        for (int x = 0; x < 5; x++) begin
            tbl[3].lanes_in[x]  = ONES;
            tbl[3].lanes_exp[x] = ONES;
        end
        for (int i = 0; i < 25; i++) exp_mem[i] = '0;

        // reset state
        @(negedge clk);
        check_int("reset_ready", int'(ready), 1);
        check_int("reset_rd", int'(mem_rd), 0);
        check_int("reset_wr", int'(mem_wr), 0);
        check_int("reset_addr", int'(mem_addr), 0);
        check_vec("reset_wdata", mem_wdata, '0);
        rst = 1'b0;
        @(negedge clk);
        check_int("post_reset_ready", int'(ready), 1);

        // table vectors
        for (int v = 0; v < 4; v++) begin
            for (int p = 0; p < 5; p++) begin
                for (int x = 0; x < 5; x++) begin
                    load_img[5*p + x] = (tbl[v].all_planes || p == int'(tbl[v].plane))
                                        ? tbl[v].lanes_in[x] : '0;
                end
            end
            load_image();
            run_job($sformatf("vec%0d", v), tbl[v].pulse_a, tbl[v].pulse_b);
            for (int p = 0; p < 5; p++) begin
                for (int x = 0; x < 5; x++) begin
                    if (tbl[v].all_planes || p == int'(tbl[v].plane))
                        check_vec($sformatf("vec%0d_lane%0d", v, 5*p + x), mem[5*p + x], tbl[v].lanes_exp[x]);
                    else
                        check_vec($sformatf("vec%0d_untouched%0d", v, 5*p + x), mem[5*p + x], '0);
                end
            end
        end

        // randomized images against the chi model
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 25; i++) load_img[i] = {$urandom, $urandom};
            load_image();
            run_job($sformatf("rand%0d", n), $urandom_range(1, 55), $urandom_range(1, 55));
        end

        // back-to-back jobs with start held high: 56-cycle period
        for (int i = 0; i < 25; i++) load_img[i] = '0;
        load_image();
        build_expected();
        rd0_q.delete();
        start = 1'b1;
        t = 0;
        while (rd0_q.size() < 2 && t < 300) begin
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        check_int("b2b_job_count", rd0_q.size() >= 2 ? 2 : rd0_q.size(), 2);
        if (rd0_q.size() >= 2) check_int("b2b_period", rd0_q[1] - rd0_q[0], 56);
        t = 0;
        while (ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_int("b2b_ready_return", int'(ready), 1);
        $display("job b2b: first_reads=%0d", rd0_q.size());

        // asynchronous reset after the 12th write
        for (int i = 0; i < 25; i++) load_img[i] = {$urandom, $urandom};
        load_image();
        build_expected();
        rd_q.delete();
        wr_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!(mem_wr === 1'b1 && mem_addr == 5'd11) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_int("rst_reached_write12", int'(mem_wr === 1'b1 && mem_addr == 5'd11), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_int("async_rst_ready", int'(ready), 1);
        check_int("async_rst_rd", int'(mem_rd), 0);
        check_int("async_rst_wr", int'(mem_wr), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            check_vec($sformatf("rst_mem%0d", i), mem[i], (i < 12) ? exp_mem[i] : init_img[i]);
        end
        check_int("rst_ready_idle", int'(ready), 1);
        $display("job reset_mid: writes_before_reset=%0d", wr_q.size());
        run_job("after_reset", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
